// File: rtl/spr_pkg.sv
// Shared constants and types for the single-port RAM (spr_design).
// Optional write-through behaviour is selected by the SPR_WRITE_THROUGH_EN macro.
package spr_pkg;

    localparam int SPR_DW    = 16;
    localparam int SPR_AW    = 8;
    localparam int SPR_DEPTH = 256;

    // Which source currently drives the read-data output
    typedef enum logic [1:0] {
        Q_SRC_ZERO  = 2'd0,
        Q_SRC_MEM   = 2'd1,
        Q_SRC_WRITE = 2'd2
    } q_src_e;

    function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
        return addr < 32'(depth);
    endfunction

endpackage

// File: rtl/spr_mem_array.sv
// Storage array for spr_design: one write port and one registered read port.
// The array and its read register carry no reset.
module spr_mem_array
    import spr_pkg::*;
#(
    parameter int DW    = SPR_DW,
    parameter int AW    = SPR_AW,
    parameter int DEPTH = SPR_DEPTH
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_d;
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register holds its value on any cycle without a read
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/spr_design.sv
// Single-port synchronous RAM with registered output, async reset and range check.
// Define SPR_WRITE_THROUGH_EN for write-first output; default is no-change on writes.
module spr_design
    import spr_pkg::*;
#(
    parameter int DW    = SPR_DW,
    parameter int AW    = SPR_AW,
    parameter int DEPTH = SPR_DEPTH
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] data,
    input  logic [AW-1:0] address,
    input  logic          WEN,
    output logic [DW-1:0] Q
);

    logic          in_range;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rd_data;
    q_src_e        q_src_d;
    q_src_e        q_src_q;

    assign in_range = addr_in_range(32'(address), DEPTH);
    assign mem_we   = WEN & in_range & ~RST;
    assign mem_re   = ~WEN & in_range & ~RST;

    spr_mem_array #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (CLK),
        .wr_en   (mem_we),
        .wr_addr (address),
        .wr_data (data),
        .rd_en   (mem_re),
        .rd_addr (address),
        .rd_data (mem_rd_data)
    );

`ifdef SPR_WRITE_THROUGH_EN
    logic [DW-1:0] wt_data_d;
    logic [DW-1:0] wt_data_q;

    always_comb begin
        q_src_d   = q_src_q;
        wt_data_d = wt_data_q;
        if (!WEN) begin
            q_src_d = in_range ? Q_SRC_MEM : Q_SRC_ZERO;
        end else if (in_range) begin
            q_src_d   = Q_SRC_WRITE;
            wt_data_d = data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wt_data_q <= '0;
        end else begin
            wt_data_q <= wt_data_d;
        end
    end
`else
    always_comb begin
        q_src_d = q_src_q;
        if (!WEN) begin
            q_src_d = in_range ? Q_SRC_MEM : Q_SRC_ZERO;
        end
    end
`endif

    // Output source flop: reset forces the zero source at once
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_src_q <= Q_SRC_ZERO;
        end else begin
            q_src_q <= q_src_d;
        end
    end

    always_comb begin
        Q = '0;
        case (q_src_q)
            Q_SRC_MEM:   Q = mem_rd_data;
`ifdef SPR_WRITE_THROUGH_EN
            Q_SRC_WRITE: Q = wt_data_q;
`endif
            default:     Q = '0;
        endcase
    end

endmodule

// File: tb/tb_spr_design.sv
// Self-checking bench for spr_design: directed scenarios plus random traffic
// compared every cycle against an array-based reference model.
module tb_spr_design;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [DW-1:0] data = '0;
    logic [AW-1:0] address = '0;
    logic          WEN = 1'b0;
    logic [DW-1:0] Q;

    spr_design #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .data    (data),
        .address (address),
        .WEN     (WEN),
        .Q       (Q)
    );

    always #5 CLK = ~CLK;

    // Reference model: plain array of words plus a "has been written" flag per word
    logic [DW-1:0] model_mem [DEPTH];
    bit            model_written [DEPTH];
    logic [DW-1:0] model_q = '0;
    bit            model_known = 1'b1;
    bit            cmp_en = 1'b0;
    int            vectors = 0;
    int            miscompares = 0;

    task automatic check_output(input string name, input logic [DW-1:0] actual,
                                input logic [DW-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: Q=%h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (cmp_en && model_known) begin
            vectors++;
            if (Q !== model_q) begin
                miscompares++;
                $display("[TB] FAIL model: Q=%h expected %h at %0t", Q, model_q, $time);
            end
        end
    end

    task automatic model_step(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (we) begin
            if (int'(a) < DEPTH) begin
                model_mem[a]     = d;
                model_written[a] = 1'b1;
`ifdef SPR_WRITE_THROUGH_EN
                model_q     = d;
                model_known = 1'b1;
`endif
            end
        end else if (int'(a) < DEPTH) begin
            model_q     = model_mem[a];
            model_known = model_written[a];
        end else begin
            model_q     = '0;
            model_known = 1'b1;
        end
    endtask

    task automatic apply_stimulus(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        WEN     = we;
        address = a;
        data    = d;
        @(posedge CLK);
        if (!RST) model_step(we, a, d);
        @(negedge CLK);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_written[i] = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check_output("reset_q", Q, 16'h0000);
        RST    = 1'b0;
        cmp_en = 1'b1;

        apply_stimulus(1'b1, 8'd0, 16'h00F0);
        apply_stimulus(1'b0, 8'd0, 16'h0000);
        check_output("rd_addr0", Q, 16'h00F0);

        apply_stimulus(1'b1, 8'd1, 16'h00E1);
        apply_stimulus(1'b1, 8'd2, 16'h00D2);
        apply_stimulus(1'b0, 8'd2, 16'h0000);
        check_output("rd_addr2", Q, 16'h00D2);
        apply_stimulus(1'b0, 8'd1, 16'h0000);
        check_output("rd_addr1", Q, 16'h00E1);

        apply_stimulus(1'b0, 8'd0, 16'h0000);
        check_output("rd_before_wr", Q, 16'h00F0);
        apply_stimulus(1'b1, 8'd0, 16'h1234);
`ifdef SPR_WRITE_THROUGH_EN
        check_output("wr_cycle_q", Q, 16'h1234);
`else
        check_output("wr_cycle_q", Q, 16'h00F0);
`endif
        apply_stimulus(1'b0, 8'd0, 16'h0000);
        check_output("rd_after_wr", Q, 16'h1234);

        // Reset between edges; the write attempted during reset must be lost
        #2 RST = 1'b1;
        model_q     = '0;
        model_known = 1'b1;
        #1 check_output("rst_async", Q, 16'h0000);
        WEN     = 1'b1;
        address = 8'd1;
        data    = 16'hBEEF;
        @(posedge CLK);
        @(negedge CLK);
        check_output("rst_hold", Q, 16'h0000);
        RST = 1'b0;
        apply_stimulus(1'b0, 8'd1, 16'h0000);
        check_output("rd_after_rst", Q, 16'h00E1);

        apply_stimulus(1'b1, 8'd255, 16'hFFFF);
        apply_stimulus(1'b1, 8'd0, 16'h0001);
        apply_stimulus(1'b0, 8'd255, 16'h0000);
        check_output("rd_top", Q, 16'hFFFF);
        apply_stimulus(1'b0, 8'd0, 16'h0000);
        check_output("rd_bottom", Q, 16'h0001);

        apply_stimulus(1'b1, 8'd7, 16'hAAAA);
        apply_stimulus(1'b1, 8'd7, 16'h5555);
        apply_stimulus(1'b0, 8'd7, 16'h0000);
        check_output("last_write_wins", Q, 16'h5555);

        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                            : AW'($urandom_range(0, 15));
            apply_stimulus(1'($urandom_range(0, 1)), a, DW'($urandom));
        end

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spr_design.md
SPR_DESIGN -- requirements
Module: spr_design

Interface
REQ-001 Parameter DW, default 16, data word width in bits.
REQ-002 Parameter AW, default 8, address width in bits.
REQ-003 Parameter DEPTH, default 256 (2**AW), number of words; DEPTH SHALL NOT exceed 2**AW.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 data  input  DW  write data.
REQ-007 address  input  AW  word address shared by read and write.
REQ-008 WEN  input  1  write enable, active-high; 1 = write, 0 = read.
REQ-009 Q  output  DW  registered read data.

Function
REQ-010 Single-port synchronous RAM: one access per cycle, either a write or a read, selected by WEN.
REQ-011 WEN=1 at rising CLK: mem[address] <= data; the write is visible to a read issued on the next edge.
REQ-012 WEN=0 at rising CLK: Q <= mem[address]; read latency exactly 1 cycle (Q valid after the edge that samples the address).
REQ-013 Q SHALL hold its last value on any cycle that does not update it (see REQ-019/020).
REQ-014 Address >= DEPTH (only possible when DEPTH < 2**AW): write ignored, read returns all zeros.
REQ-015 X/Z bits on data are stored as-is in simulation; no data sanitising.
REQ-016 Unwritten locations return an undefined value; no array initialisation is required.
REQ-017 Back-to-back writes to the same address: the last write wins; a read on the next cycle returns the last-written value.

Reset
REQ-018 RST=1 SHALL immediately (asynchronously) force Q to 0 and hold it there while asserted; the memory array is NOT cleared, and writes presented while RST=1 SHALL be ignored; the first access is taken on the first rising CLK after deassertion.

Configuration
REQ-019 Macro SPR_WRITE_THROUGH_EN defined: on a write cycle Q <= data (write-first behaviour).
REQ-020 Macro SPR_WRITE_THROUGH_EN undefined (default): on a write cycle Q holds its previous value (no-change behaviour).

Structure
REQ-021 Package spr_pkg SHALL hold the default constants SPR_DW=16, SPR_AW=8, SPR_DEPTH=256, used as parameter defaults.
REQ-022 Storage SHALL be a sub-module spr_mem_array (write port plus synchronous read port, no reset); spr_design adds the output register, reset, range check, and write-through option.

Verification
REQ-023 WEN=1, address=0, data=0x00F0 for one edge; then WEN=0, address=0 -> Q=0x00F0 one cycle later.
REQ-024 Write 0x00E1 to address 1 and 0x00D2 to address 2; read addresses 2, then 1 on consecutive cycles -> Q=0x00D2, then 0x00E1, each 1 cycle after its address.
REQ-025 Read address 0 (Q=0x00F0), then write 0x1234 to address 0 -> Q stays 0x00F0 during the write (default build), or Q=0x1234 (with SPR_WRITE_THROUGH_EN); a subsequent read returns 0x1234.
REQ-026 Assert RST mid-sequence between clock edges -> Q=0 immediately; after deassertion, a read of address 1 returns 0x00E1 (contents retained).
REQ-027 Write to address 255 = 0xFFFF, then to address 0 = 0x0001 -> reads return 0xFFFF and 0x0001 (no aliasing at the top address).
